// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//
// Shares the single unified-L2 block port between the I-cache miss interface
// and the D-cache miss interface. One 128-bit block transaction is in flight
// at a time. The owner's read/write/addr/wdata are muxed onto the L2 port,
// read data is broadcast to both caches, and mem_ready is routed only to the
// owner.
//
// Optional feature macro: ARB_FIXED_PRIO_EN
//   undefined : round-robin on ties (first tie after reset goes to I).
//   defined   : D wins ties until it has taken MAX_BURST consecutive
//               contended grants; then I is forced once.
//
// Ports
//   clk            in   clock, all state on rising edge
//   proc_reset_n   in   asynchronous active-low reset
//   i_mem_read     in   I-cache block read request (level)
//   i_mem_addr     in   I-cache block address
//   i_mem_rdata    out  read data to I-cache (= mem_rdata)
//   i_mem_ready    out  transaction done for I-cache
//   d_mem_read     in   D-cache block read request
//   d_mem_write    in   D-cache block write-back request
//   d_mem_addr     in   D-cache block address
//   d_mem_wdata    in   D-cache write-back data
//   d_mem_rdata    out  read data to D-cache (= mem_rdata)
//   d_mem_ready    out  transaction done for D-cache
//   mem_read       out  L2 read request
//   mem_write      out  L2 write request
//   mem_addr       out  L2 block address
//   mem_wdata      out  L2 write data
//   mem_rdata      in   L2 read data
//   mem_ready      in   L2 completion, one-cycle pulse
//   arb_busy       out  state != IDLE
//   arb_grant_d    out  state == SERVE_D
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              arb_busy,
  output logic              arb_grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t r_state;
  logic   r_last_d;     // 1: most recent completed grant was D
  logic   r_busy;
  logic   r_grant_d;

  logic   w_req_i;
  logic   w_req_d;
  logic   w_tie_pick_i; // on a tie, 1 selects I

  assign w_req_i = i_mem_read;
  assign w_req_d = d_mem_read | d_mem_write;

`ifdef ARB_FIXED_PRIO_EN
  localparam int STREAK_W = $clog2(MAX_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_BURST);

  logic [STREAK_W-1:0] r_d_streak;
  // Remembers whether I was also requesting when the current D grant was made;
  // only such contended grants count towards the burst limit.
  logic                r_d_contended;
  logic                w_unused_last;

  assign w_tie_pick_i  = (r_d_streak == STREAK_MAX);
  assign w_unused_last = r_last_d;
`else
  logic w_unused_cfg;

  assign w_tie_pick_i = r_last_d;
  assign w_unused_cfg = (MAX_BURST != 0);
`endif

  // Control FSM; status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state       <= IDLE;
      r_last_d      <= 1'b1;
      r_busy        <= 1'b0;
      r_grant_d     <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      r_d_streak    <= '0;
      r_d_contended <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_i && (!w_req_d || w_tie_pick_i)) begin
            r_state   <= SERVE_I;
            r_busy    <= 1'b1;
            r_grant_d <= 1'b0;
          end else if (w_req_d) begin
            r_state   <= SERVE_D;
            r_busy    <= 1'b1;
            r_grant_d <= 1'b1;
`ifdef ARB_FIXED_PRIO_EN
            r_d_contended <= w_req_i;
`endif
          end
        end
        // The grant is held until the L2 completes, even if the owner
        // withdraws its request: the L2 already owns the transaction.
        SERVE_I: begin
          if (mem_ready) begin
            r_state  <= RELEASE;
            r_last_d <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
            r_d_streak <= '0;
`endif
          end
        end
        SERVE_D: begin
          if (mem_ready) begin
            r_state   <= RELEASE;
            r_grant_d <= 1'b0;
            r_last_d  <= 1'b1;
`ifdef ARB_FIXED_PRIO_EN
            if (r_d_contended && (r_d_streak != STREAK_MAX))
              r_d_streak <= r_d_streak + 1'b1;
`endif
          end
        end
        // One dead cycle lets the cache drop its request after its
        // registered ready, so a stale request is never re-issued.
        RELEASE: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_grant_d <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_grant_d <= 1'b0;
        end
      endcase
    end
  end

  // L2 port mux. Address/data are zeroed whenever no request is driven so
  // the L2 never sees stale fields.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (r_state)
      SERVE_I: begin
        mem_read    = i_mem_read;
        if (w_req_i) mem_addr = i_mem_addr;
        i_mem_ready = mem_ready;
      end
      SERVE_D: begin
        mem_read  = d_mem_read;
        mem_write = d_mem_write;
        if (w_req_d) begin
          mem_addr  = d_mem_addr;
          mem_wdata = d_mem_wdata;
        end
        d_mem_ready = mem_ready;
      end
      default: begin
      end
    endcase
  end

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign arb_busy    = r_busy;
  assign arb_grant_d = r_grant_d;

endmodule
